// File: rtl/dmem_responder.sv
`default_nettype none
// dmem_responder: word-addressed data memory that answers reads after a fixed latency.
// Define DMEM_WAIT_EN to build the WAIT state, latency counter and o_stall; otherwise reads answer in one cycle.
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_read_en,
  input  logic        i_write_en,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic        o_read_vd,
  output logic        o_stall,
  output logic        o_err
);

  localparam int unsigned AW = $clog2(DEPTH);

`ifdef DMEM_WAIT_EN
  localparam int unsigned EFF_LATENCY = LATENCY;
  localparam int unsigned SW          = 2;
  localparam int unsigned CW          = 4;
  localparam logic [1:0]  IDLE        = 2'd0;
  localparam logic [1:0]  WAIT        = 2'd1;
  localparam logic [1:0]  RESP        = 2'd2;
`else
  // Without wait-state logic every read answers on the next cycle.
  localparam int unsigned EFF_LATENCY = (LATENCY >= 1) ? 1 : 1;
  localparam int unsigned SW          = 1;
  localparam logic [0:0]  IDLE        = 1'b0;
  localparam logic [0:0]  RESP        = 1'b1;
`endif

  logic [31:0]   mem_q [DEPTH];

  logic [SW-1:0] state_q, state_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          err_q, err_d;

`ifdef DMEM_WAIT_EN
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          in_range_q, in_range_d;
`endif

  logic [AW-1:0] req_idx;
  logic          req_in_range;
  logic          accept;
  logic          wr_req;
  logic          rd_req;
  logic          mem_we;
  logic          unused_addr_lsb;

  assign req_idx         = i_addr[AW+1:2];
  assign req_in_range    = (i_addr[31:AW+2] == '0);
  assign unused_addr_lsb = ^i_addr[1:0];

  assign accept = (state_q == IDLE) || (state_q == RESP);
  // A simultaneous read and write is resolved as a write; the read is dropped.
  assign wr_req = accept && i_write_en;
  assign rd_req = accept && i_read_en && !i_write_en;
  assign mem_we = wr_req && req_in_range;

  always_comb begin
    state_d   = IDLE;
    rd_data_d = rd_data_q;
    err_d     = 1'b0;
`ifdef DMEM_WAIT_EN
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    in_range_d = in_range_q;
`endif
    if (wr_req) begin
      state_d = IDLE;
      err_d   = !req_in_range || i_read_en;
    end else if (rd_req) begin
      if (EFF_LATENCY == 1) begin
        state_d   = RESP;
        rd_data_d = req_in_range ? mem_q[req_idx] : '0;
        err_d     = !req_in_range;
      end
`ifdef DMEM_WAIT_EN
      else begin
        state_d    = WAIT;
        cnt_d      = CW'(EFF_LATENCY - 2);
        addr_d     = req_idx;
        in_range_d = req_in_range;
      end
`endif
    end
`ifdef DMEM_WAIT_EN
    else if (state_q == WAIT) begin
      // Storage cannot change while waiting, so sampling it on the last WAIT edge is safe.
      if (cnt_q == '0) begin
        state_d   = RESP;
        rd_data_d = in_range_q ? mem_q[addr_q] : '0;
        err_d     = !in_range_q;
      end else begin
        state_d = WAIT;
        cnt_d   = cnt_q - 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
`ifdef DMEM_WAIT_EN
      cnt_q      <= '0;
      addr_q     <= '0;
      in_range_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
`ifdef DMEM_WAIT_EN
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      in_range_q <= in_range_d;
`endif
    end
  end

  // Storage is deliberately outside the reset domain so its contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[req_idx] <= i_write_data;
    end
  end

  assign o_read_data = rd_data_q;
  assign o_read_vd   = (state_q == RESP);
  assign o_err       = err_q;
`ifdef DMEM_WAIT_EN
  assign o_stall     = (state_q == WAIT);
`else
  assign o_stall     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// tb_dmem_responder: randomized requests checked against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int LAT   = 3;
`ifdef DMEM_WAIT_EN
  localparam int EL = LAT;
`else
  localparam int EL = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_addr = '0;
  logic        i_read_en = 1'b0;
  logic        i_write_en = 1'b0;
  logic [31:0] i_write_data = '0;
  logic [31:0] o_read_data;
  logic        o_read_vd;
  logic        o_stall;
  logic        o_err;

  dmem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_addr       (i_addr),
    .i_read_en    (i_read_en),
    .i_write_en   (i_write_en),
    .i_write_data (i_write_data),
    .o_read_data  (o_read_data),
    .o_read_vd    (o_read_vd),
    .o_stall      (o_stall),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >> 2) < 32'(DEPTH);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_read_en    = 1'b0;
    i_write_en   = 1'b0;
    i_addr       = '0;
    i_write_data = '0;
  endtask

  task automatic idle_cycle();
    clear_inputs();
    tick();
    check_eq("idle_vd", 32'(o_read_vd), 32'd0);
    check_eq("idle_stall", 32'(o_stall), 32'd0);
    check_eq("idle_err", 32'(o_err), 32'd0);
    check_eq("idle_hold", o_read_data, last_data);
  endtask

  // Issues a read, checks every stall cycle, and returns in the response cycle.
  task automatic read_txn(input logic [31:0] a);
    bit          inr;
    logic [31:0] exp;
    inr = in_rng(a);
    exp = inr ? ref_mem[a[AW+1:2]] : 32'd0;
    i_addr       = a;
    i_read_en    = 1'b1;
    i_write_en   = 1'b0;
    i_write_data = $urandom;
    tick();
    for (int k = 1; k < EL; k++) begin
      check_eq("wait_stall", 32'(o_stall), 32'd1);
      check_eq("wait_vd", 32'(o_read_vd), 32'd0);
      check_eq("wait_err", 32'(o_err), 32'd0);
      check_eq("wait_hold", o_read_data, last_data);
      // Anything driven while stalled must be ignored.
      i_read_en    = 1'($urandom);
      i_write_en   = 1'($urandom);
      i_addr       = $urandom;
      i_write_data = $urandom;
      tick();
    end
    check_eq("resp_vd", 32'(o_read_vd), 32'd1);
    check_eq("resp_stall", 32'(o_stall), 32'd0);
    check_eq("resp_data", o_read_data, exp);
    check_eq("resp_err", 32'(o_err), 32'(!inr));
    last_data = exp;
    clear_inputs();
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input bit both);
    bit inr;
    inr = in_rng(a);
    i_addr       = a;
    i_write_en   = 1'b1;
    i_read_en    = both;
    i_write_data = d;
    tick();
    if (inr) ref_mem[a[AW+1:2]] = d;
    check_eq("wr_vd", 32'(o_read_vd), 32'd0);
    check_eq("wr_stall", 32'(o_stall), 32'd0);
    check_eq("wr_err", 32'(o_err), 32'(!inr || both));
    check_eq("wr_hold", o_read_data, last_data);
    clear_inputs();
  endtask

  function automatic logic [31:0] rnd_in_addr();
    return 32'($urandom_range(0, DEPTH * 4 - 1));
  endfunction

  function automatic logic [31:0] rnd_oor_addr();
    case ($urandom_range(0, 2))
      0:       return 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
      1:       return 32'hFFFF_FFFC;
      default: return $urandom | 32'h8000_0000;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b0;
    #2;
    check_eq("rst_data", o_read_data, 32'd0);
    check_eq("rst_vd", 32'(o_read_vd), 32'd0);
    check_eq("rst_stall", 32'(o_stall), 32'd0);
    check_eq("rst_err", 32'(o_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int w = 0; w < DEPTH; w++) begin
      write_txn(32'(w * 4), $urandom, 1'b0);
    end
    idle_cycle();

    write_txn(32'h10, 32'hDEAD_BEEF, 1'b0);
    read_txn(32'h10);
    idle_cycle();

    read_txn(32'h0);
    read_txn(32'h4);
    idle_cycle();

    read_txn(32'(DEPTH * 4));
    write_txn(32'(DEPTH * 4), 32'hA5A5_5A5A, 1'b0);
    read_txn(32'h0);
    read_txn(32'(DEPTH * 4 - 1));
    idle_cycle();

    write_txn(32'h20, 32'h1234_5678, 1'b1);
    read_txn(32'h20);
    idle_cycle();

    // Reset while a read is in flight: the response must never appear.
    i_addr    = 32'h40;
    i_read_en = 1'b1;
    tick();
    clear_inputs();
    if (EL >= 3) tick();
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_vd", 32'(o_read_vd), 32'd0);
    check_eq("midrst_stall", 32'(o_stall), 32'd0);
    check_eq("midrst_data", o_read_data, 32'd0);
    check_eq("midrst_err", 32'(o_err), 32'd0);
    last_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_eq("postrst_vd", 32'(o_read_vd), 32'd0);
    check_eq("postrst_data", o_read_data, 32'd0);
    read_txn(32'h10);
    idle_cycle();

    for (int t = 0; t < 400; t++) begin
      int unsigned sel;
      int unsigned gap;
      sel = $urandom_range(0, 99);
      gap = ($urandom_range(0, 3) > 1) ? $urandom_range(1, 2) : 0;
      if (sel < 50)      read_txn(rnd_in_addr());
      else if (sel < 60) read_txn(rnd_oor_addr());
      else if (sel < 85) write_txn(rnd_in_addr(), $urandom, 1'b0);
      else if (sel < 90) write_txn(rnd_oor_addr(), $urandom, 1'b0);
      else               write_txn(rnd_in_addr(), $urandom, 1'b1);
      for (int g = 0; g < int'(gap); g++) idle_cycle();
    end
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
